// File: rtl/control_unit.sv
// Moore control FSM for the 8-bit accumulator computer: fetch, decode and
// per-opcode execute sequences driving the datapath enables and bus selects.
module control_unit (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [7:0] IR,
    input  logic [3:0] CCR_Result,
    output logic       IR_Load,
    output logic       MAR_Load,
    output logic       PC_Load,
    output logic       PC_Inc,
    output logic       A_Load,
    output logic       B_Load,
    output logic       CCR_Load,
    output logic [2:0] ALU_Sel,
    output logic [1:0] Bus1_Sel,
    output logic [1:0] Bus2_Sel,
    output logic       write
);

    localparam logic [7:0] LDA_IMM = 8'h86;
    localparam logic [7:0] LDA_DIR = 8'h87;
    localparam logic [7:0] LDB_IMM = 8'h88;
    localparam logic [7:0] LDB_DIR = 8'h89;
    localparam logic [7:0] STA_DIR = 8'h96;
    localparam logic [7:0] STB_DIR = 8'h97;
    localparam logic [7:0] ADD_AB  = 8'h42;
    localparam logic [7:0] SUB_AB  = 8'h43;
    localparam logic [7:0] AND_AB  = 8'h44;
    localparam logic [7:0] OR_AB   = 8'h45;
    localparam logic [7:0] INCA    = 8'h46;
    localparam logic [7:0] DECA    = 8'h47;
    localparam logic [7:0] INCB    = 8'h48;
    localparam logic [7:0] DECB    = 8'h49;
    localparam logic [7:0] BRA     = 8'h20;
    localparam logic [7:0] BMI     = 8'h21;
    localparam logic [7:0] BPL     = 8'h22;
    localparam logic [7:0] BEQ     = 8'h23;
    localparam logic [7:0] BNE     = 8'h24;
    localparam logic [7:0] BVS     = 8'h25;
    localparam logic [7:0] BVC     = 8'h26;
    localparam logic [7:0] BCS     = 8'h27;
    localparam logic [7:0] BCC     = 8'h28;

    typedef enum logic [5:0] {
        S_FETCH_0, S_FETCH_1, S_FETCH_2, S_DECODE_3,
        S_LDA_IMM_4, S_LDA_IMM_5, S_LDA_IMM_6,
        S_LDA_DIR_4, S_LDA_DIR_5, S_LDA_DIR_6, S_LDA_DIR_7, S_LDA_DIR_8,
        S_LDB_IMM_4, S_LDB_IMM_5, S_LDB_IMM_6,
        S_LDB_DIR_4, S_LDB_DIR_5, S_LDB_DIR_6, S_LDB_DIR_7, S_LDB_DIR_8,
        S_STA_DIR_4, S_STA_DIR_5, S_STA_DIR_6, S_STA_DIR_7,
        S_STB_DIR_4, S_STB_DIR_5, S_STB_DIR_6, S_STB_DIR_7,
        S_ADD_4, S_SUB_4, S_AND_4, S_OR_4,
        S_INCA_4, S_DECA_4, S_INCB_4, S_DECB_4,
        S_BR_4, S_BR_5, S_BR_6, S_BR_SKIP_4
    } state_t;

    state_t state, next_state;
    logic   branch_taken;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset)
            state <= S_FETCH_0;
        else
            state <= next_state;
    end

    // Flags are {N,Z,V,C}; odd branch opcodes test for a set flag, even for clear.
    always_comb begin
        branch_taken = 1'b0;
        case (IR)
            BRA: branch_taken = 1'b1;
            BMI: branch_taken = CCR_Result[3];
            BPL: branch_taken = ~CCR_Result[3];
            BEQ: branch_taken = CCR_Result[2];
            BNE: branch_taken = ~CCR_Result[2];
            BVS: branch_taken = CCR_Result[1];
            BVC: branch_taken = ~CCR_Result[1];
            BCS: branch_taken = CCR_Result[0];
            BCC: branch_taken = ~CCR_Result[0];
            default: branch_taken = 1'b0;
        endcase
    end

    always_comb begin
        next_state = S_FETCH_0;
        IR_Load    = 1'b0;
        MAR_Load   = 1'b0;
        PC_Load    = 1'b0;
        PC_Inc     = 1'b0;
        A_Load     = 1'b0;
        B_Load     = 1'b0;
        CCR_Load   = 1'b0;
        ALU_Sel    = 3'b000;
        Bus1_Sel   = 2'b00;
        Bus2_Sel   = 2'b00;
        write      = 1'b0;

        // Outputs stay at their defaults for as long as Reset is held low.
        if (Reset) begin
            case (state)
                S_FETCH_0: begin
                    Bus2_Sel   = 2'b01;
                    MAR_Load   = 1'b1;
                    next_state = S_FETCH_1;
                end
                S_FETCH_1: begin
                    PC_Inc     = 1'b1;
                    next_state = S_FETCH_2;
                end
                S_FETCH_2: begin
                    Bus2_Sel   = 2'b10;
                    IR_Load    = 1'b1;
                    next_state = S_DECODE_3;
                end
                S_DECODE_3: begin
                    case (IR)
                        LDA_IMM: next_state = S_LDA_IMM_4;
                        LDA_DIR: next_state = S_LDA_DIR_4;
                        LDB_IMM: next_state = S_LDB_IMM_4;
                        LDB_DIR: next_state = S_LDB_DIR_4;
                        STA_DIR: next_state = S_STA_DIR_4;
                        STB_DIR: next_state = S_STB_DIR_4;
                        ADD_AB:  next_state = S_ADD_4;
                        SUB_AB:  next_state = S_SUB_4;
                        AND_AB:  next_state = S_AND_4;
                        OR_AB:   next_state = S_OR_4;
                        INCA:    next_state = S_INCA_4;
                        DECA:    next_state = S_DECA_4;
                        INCB:    next_state = S_INCB_4;
                        DECB:    next_state = S_DECB_4;
                        BRA, BMI, BPL, BEQ, BNE, BVS, BVC, BCS, BCC:
                            next_state = branch_taken ? S_BR_4 : S_BR_SKIP_4;
                        default: next_state = S_FETCH_0;
                    endcase
                end

                // Operand address fetch shared in shape by loads, stores and taken branches.
                S_LDA_IMM_4, S_LDA_DIR_4, S_LDB_IMM_4, S_LDB_DIR_4,
                S_STA_DIR_4, S_STB_DIR_4, S_BR_4: begin
                    Bus2_Sel = 2'b01;
                    MAR_Load = 1'b1;
                    case (state)
                        S_LDA_IMM_4: next_state = S_LDA_IMM_5;
                        S_LDA_DIR_4: next_state = S_LDA_DIR_5;
                        S_LDB_IMM_4: next_state = S_LDB_IMM_5;
                        S_LDB_DIR_4: next_state = S_LDB_DIR_5;
                        S_STA_DIR_4: next_state = S_STA_DIR_5;
                        S_STB_DIR_4: next_state = S_STB_DIR_5;
                        default:     next_state = S_BR_5;
                    endcase
                end
                S_LDA_IMM_5, S_LDA_DIR_5, S_LDB_IMM_5, S_LDB_DIR_5,
                S_STA_DIR_5, S_STB_DIR_5, S_BR_5: begin
                    PC_Inc = 1'b1;
                    case (state)
                        S_LDA_IMM_5: next_state = S_LDA_IMM_6;
                        S_LDA_DIR_5: next_state = S_LDA_DIR_6;
                        S_LDB_IMM_5: next_state = S_LDB_IMM_6;
                        S_LDB_DIR_5: next_state = S_LDB_DIR_6;
                        S_STA_DIR_5: next_state = S_STA_DIR_6;
                        S_STB_DIR_5: next_state = S_STB_DIR_6;
                        default:     next_state = S_BR_6;
                    endcase
                end

                S_LDA_IMM_6: begin
                    Bus2_Sel = 2'b10;
                    A_Load   = 1'b1;
                end
                S_LDB_IMM_6: begin
                    Bus2_Sel = 2'b10;
                    B_Load   = 1'b1;
                end
                S_BR_6: begin
                    Bus2_Sel = 2'b10;
                    PC_Load  = 1'b1;
                end

                // Direct addressing: memory operand becomes the new MAR, then one wait state.
                S_LDA_DIR_6, S_LDB_DIR_6, S_STA_DIR_6, S_STB_DIR_6: begin
                    Bus2_Sel = 2'b10;
                    MAR_Load = 1'b1;
                    case (state)
                        S_LDA_DIR_6: next_state = S_LDA_DIR_7;
                        S_LDB_DIR_6: next_state = S_LDB_DIR_7;
                        S_STA_DIR_6: next_state = S_STA_DIR_7;
                        default:     next_state = S_STB_DIR_7;
                    endcase
                end
                S_LDA_DIR_7: next_state = S_LDA_DIR_8;
                S_LDB_DIR_7: next_state = S_LDB_DIR_8;
                S_LDA_DIR_8: begin
                    Bus2_Sel = 2'b10;
                    A_Load   = 1'b1;
                end
                S_LDB_DIR_8: begin
                    Bus2_Sel = 2'b10;
                    B_Load   = 1'b1;
                end
                S_STA_DIR_7: begin
                    Bus1_Sel = 2'b01;
                    write    = 1'b1;
                end
                S_STB_DIR_7: begin
                    Bus1_Sel = 2'b10;
                    write    = 1'b1;
                end

                S_ADD_4:  begin ALU_Sel = 3'b000; CCR_Load = 1'b1; A_Load = 1'b1; end
                S_SUB_4:  begin ALU_Sel = 3'b001; CCR_Load = 1'b1; A_Load = 1'b1; end
                S_AND_4:  begin ALU_Sel = 3'b010; CCR_Load = 1'b1; A_Load = 1'b1; end
                S_OR_4:   begin ALU_Sel = 3'b011; CCR_Load = 1'b1; A_Load = 1'b1; end
                S_INCA_4: begin ALU_Sel = 3'b100; CCR_Load = 1'b1; A_Load = 1'b1; end
                S_DECA_4: begin ALU_Sel = 3'b101; CCR_Load = 1'b1; A_Load = 1'b1; end
                S_INCB_4: begin ALU_Sel = 3'b110; CCR_Load = 1'b1; B_Load = 1'b1; end
                S_DECB_4: begin ALU_Sel = 3'b111; CCR_Load = 1'b1; B_Load = 1'b1; end

                S_BR_SKIP_4: PC_Inc = 1'b1;

                default: next_state = S_FETCH_0;
            endcase
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: per-cycle output vectors are compared
// against an instruction-level model of each opcode's micro-sequence.
module tb_control_unit;

    typedef logic [14:0] vec_t;

    logic       Clk;
    logic       Reset;
    logic [7:0] IR;
    logic [3:0] CCR_Result;
    logic       IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, CCR_Load;
    logic [2:0] ALU_Sel;
    logic [1:0] Bus1_Sel, Bus2_Sel;
    logic       write;

    int   tests    = 0;
    int   failures = 0;
    vec_t expq[$];

    logic [7:0] opTable [23] = '{8'h86, 8'h87, 8'h88, 8'h89, 8'h96, 8'h97,
                                 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h48, 8'h49,
                                 8'h20, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h28};

    control_unit dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .IR        (IR),
        .CCR_Result(CCR_Result),
        .IR_Load   (IR_Load),
        .MAR_Load  (MAR_Load),
        .PC_Load   (PC_Load),
        .PC_Inc    (PC_Inc),
        .A_Load    (A_Load),
        .B_Load    (B_Load),
        .CCR_Load  (CCR_Load),
        .ALU_Sel   (ALU_Sel),
        .Bus1_Sel  (Bus1_Sel),
        .Bus2_Sel  (Bus2_Sel),
        .write     (write)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic vec_t mk(input logic irl, input logic mar, input logic pcl, input logic pci,
                                input logic al, input logic bl, input logic ccr,
                                input logic [2:0] alu, input logic [1:0] b1, input logic [1:0] b2,
                                input logic w);
        return {irl, mar, pcl, pci, al, bl, ccr, alu, b1, b2, w};
    endfunction

    // Builds the expected per-cycle output list for one instruction.
    function automatic void buildModel(input logic [7:0] op, input logic [3:0] ccr);
        vec_t idle, marPc, incPc, marMem;
        int   idx;
        logic flag, taken;
        idle   = '0;
        marPc  = mk(0, 1, 0, 0, 0, 0, 0, 3'b000, 2'b00, 2'b01, 0);
        incPc  = mk(0, 0, 0, 1, 0, 0, 0, 3'b000, 2'b00, 2'b00, 0);
        marMem = mk(0, 1, 0, 0, 0, 0, 0, 3'b000, 2'b00, 2'b10, 0);
        expq.delete();
        expq.push_back(marPc);
        expq.push_back(incPc);
        expq.push_back(mk(1, 0, 0, 0, 0, 0, 0, 3'b000, 2'b00, 2'b10, 0));
        expq.push_back(idle);
        if (op == 8'h86 || op == 8'h88) begin
            expq.push_back(marPc);
            expq.push_back(incPc);
            expq.push_back(mk(0, 0, 0, 0, op == 8'h86, op == 8'h88, 0, 3'b000, 2'b00, 2'b10, 0));
        end else if (op == 8'h87 || op == 8'h89) begin
            expq.push_back(marPc);
            expq.push_back(incPc);
            expq.push_back(marMem);
            expq.push_back(idle);
            expq.push_back(mk(0, 0, 0, 0, op == 8'h87, op == 8'h89, 0, 3'b000, 2'b00, 2'b10, 0));
        end else if (op == 8'h96 || op == 8'h97) begin
            expq.push_back(marPc);
            expq.push_back(incPc);
            expq.push_back(marMem);
            expq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 3'b000, (op == 8'h96) ? 2'b01 : 2'b10, 2'b00, 1));
        end else if (op >= 8'h42 && op <= 8'h49) begin
            expq.push_back(mk(0, 0, 0, 0, op <= 8'h47, op > 8'h47, 1, 3'(op - 8'h42), 2'b00, 2'b00, 0));
        end else if (op >= 8'h20 && op <= 8'h28) begin
            idx = int'(op) - 32;
            if (idx == 0) begin
                taken = 1'b1;
            end else begin
                flag  = ccr[3 - (idx - 1) / 2];
                taken = (flag == ((idx % 2) == 1));
            end
            if (taken) begin
                expq.push_back(marPc);
                expq.push_back(incPc);
                expq.push_back(mk(0, 0, 1, 0, 0, 0, 0, 3'b000, 2'b00, 2'b10, 0));
            end else begin
                expq.push_back(incPc);
            end
        end
    endfunction

    task automatic checkOutput(input string tag, input vec_t expected);
        vec_t obs;
        obs = {IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, CCR_Load,
               ALU_Sel, Bus1_Sel, Bus2_Sel, write};
        tests++;
        assert (obs === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, expected);
        end
    endtask

    // Runs one instruction from S_FETCH_0; abortAt >= 0 pulses Reset in that cycle.
    task automatic applyStimulus(input logic [7:0] op, input logic [3:0] ccr, input int abortAt);
        buildModel(op, ccr);
        for (int k = 0; k < expq.size(); k++) begin
            if (k == 3) begin
                IR         = op;
                CCR_Result = ccr;
            end else begin
                IR         = 8'($urandom);
                CCR_Result = 4'($urandom);
            end
            #1;
            checkOutput($sformatf("op%02h_cycle%0d", op, k + 1), expq[k]);
            if (k == abortAt) begin
                #1 Reset = 1'b0;
                #1 checkOutput($sformatf("op%02h_async_reset_c%0d", op, k + 1), '0);
                @(posedge Clk);
                #1 checkOutput("reset_held_low", '0);
                @(negedge Clk);
                Reset = 1'b1;
                #1;
                return;
            end
            @(posedge Clk);
            #1;
        end
    endtask

    initial begin
        logic [7:0] op;
        int         abortAt;
        Reset      = 1'b0;
        IR         = 8'h00;
        CCR_Result = 4'h0;
        #2 checkOutput("reset_low_initial", '0);
        @(posedge Clk);
        #1 checkOutput("reset_low_clocked", '0);
        @(negedge Clk);
        Reset = 1'b1;
        #1;

        applyStimulus(8'h86, 4'h0, -1);
        applyStimulus(8'h97, 4'($urandom), -1);
        applyStimulus(8'h43, 4'($urandom), -1);
        applyStimulus(8'h49, 4'($urandom), -1);
        applyStimulus(8'h23, 4'b0100, -1);
        applyStimulus(8'h23, 4'b0000, -1);
        applyStimulus(8'hFF, 4'($urandom), -1);
        applyStimulus(8'h96, 4'($urandom), 7);
        applyStimulus(8'h87, 4'($urandom), -1);

        for (int n = 0; n < 250; n++) begin
            if ($urandom_range(0, 7) == 0)
                op = 8'($urandom);
            else
                op = opTable[$urandom_range(0, 22)];
            abortAt = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 8)) : -1;
            applyStimulus(op, 4'($urandom), abortAt);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 Clk  input  1  system clock; all state updates on rising edge.
REQ-003 Reset  input  1  asynchronous, active-low reset; state SHALL clear immediately on Reset=0.
REQ-004 IR  input  8  current opcode from the datapath instruction register.
REQ-005 CCR_Result  input  4  flags {N,Z,V,C} (bit3..bit0) from the datapath CCR.
REQ-006 IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, CCR_Load  output  1 each  datapath register enables.
REQ-007 ALU_Sel  output  3  ALU operation: 000 A+B, 001 A-B, 010 A&B, 011 A|B, 100 A+1, 101 A-1, 110 B+1, 111 B-1.
REQ-008 Bus1_Sel  output  2  00 PC, 01 A, 10 B.
REQ-009 Bus2_Sel  output  2  00 ALU result, 01 Bus1, 10 from_memory.
REQ-010 write  output  1  memory write strobe; memory captures to_memory at address on the rising edge while write=1.

Function
REQ-011 Outputs SHALL be Moore: a combinational decode of state (and of IR/CCR_Result in S_DECODE_3 only); defaults are all enables 0, write 0, all selects 000/00.
REQ-012 Memory read data SHALL be valid one cycle after MAR_Load; every read waits one state after MAR_Load.
REQ-013 Fetch: S_FETCH_0 (Bus1_Sel=00, Bus2_Sel=01, MAR_Load) -> S_FETCH_1 (PC_Inc) -> S_FETCH_2 (Bus2_Sel=10, IR_Load) -> S_DECODE_3.
REQ-014 Opcodes: 0x86 LDA_IMM, 0x87 LDA_DIR, 0x88 LDB_IMM, 0x89 LDB_DIR, 0x96 STA_DIR, 0x97 STB_DIR, 0x42 ADD, 0x43 SUB, 0x44 AND, 0x45 OR, 0x46 INCA, 0x47 DECA, 0x48 INCB, 0x49 DECB, 0x20 BRA, 0x21 BMI, 0x22 BPL, 0x23 BEQ, 0x24 BNE, 0x25 BVS, 0x26 BVC, 0x27 BCS, 0x28 BCC.
REQ-015 Operand fetch (LD*, ST*, branches taken): S4 MAR<=PC (Bus1_Sel=00, Bus2_Sel=01, MAR_Load) -> S5 PC_Inc.
REQ-016 IMM loads: S6 Bus2_Sel=10 with A_Load or B_Load -> S_FETCH_0; total 7 cycles.
REQ-017 DIR loads: S6 MAR<=from_memory (Bus2_Sel=10, MAR_Load) -> S7 wait -> S8 Bus2_Sel=10, A_Load/B_Load -> S_FETCH_0; total 9 cycles.
REQ-018 DIR stores: S6 MAR<=from_memory -> S7 Bus1_Sel=01 (STA) or 10 (STB), write=1 -> S_FETCH_0; total 8 cycles.
REQ-019 ALU ops: S4 Bus2_Sel=00, ALU_Sel per REQ-007, CCR_Load=1, A_Load (ADD..DECA) or B_Load (INCB, DECB) -> S_FETCH_0; total 5 cycles.
REQ-020 Branch condition SHALL be sampled in S_DECODE_3: BRA always; BMI N=1; BPL N=0; BEQ Z=1; BNE Z=0; BVS V=1; BVC V=0; BCS C=1; BCC C=0.
REQ-021 Taken branch: REQ-015 then S6 Bus2_Sel=10, PC_Load -> S_FETCH_0; total 7 cycles.
REQ-022 Not-taken branch: S4 PC_Inc (skip operand) -> S_FETCH_0; total 5 cycles.
REQ-023 Undefined opcode SHALL act as a 4-cycle NOP: S_DECODE_3 -> S_FETCH_0, no enables asserted in S_DECODE_3.
REQ-024 PC_Load and PC_Inc SHALL never be asserted together; write SHALL never coincide with any load.
REQ-025 Unreachable state encodings SHALL return to S_FETCH_0 on the next edge.

Reset
REQ-026 Reset=0 SHALL force state to S_FETCH_0 asynchronously, mid-instruction included, and gate all outputs to defaults while low.
REQ-027 First rising Clk with Reset=1 SHALL execute S_FETCH_0 outputs.

Verification
REQ-028 Reset pulse during S7 of STA_DIR -> write drops to 0 immediately; after release, S_FETCH_0 with MAR_Load=1, Bus2_Sel=01.
REQ-029 IR=0x86 -> 7-cycle sequence; A_Load=1, Bus2_Sel=10 only in cycle 7; PC_Inc exactly twice.
REQ-030 IR=0x97 -> write=1 for exactly one cycle with Bus1_Sel=10, in cycle 8.
REQ-031 IR=0x43 -> cycle 5 ALU_Sel=001, A_Load=1, CCR_Load=1, Bus2_Sel=00; IR=0x49 -> ALU_Sel=111, B_Load=1.
REQ-032 IR=0x23 with CCR_Result=0100 -> PC_Load in cycle 7; with 0000 -> PC_Inc in cycle 5, no PC_Load, next S_FETCH_0.
REQ-033 IR=0xFF -> S_FETCH_0 follows S_DECODE_3; all enables and write stay 0 in S_DECODE_3.
